// File: rtl/branch_pkg.sv
// Shared encodings for the branch/PC controller: funct3 branch conditions,
// controller states, trap causes and the default reset PC.
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      COMMIT = 2'd2,
      TRAP   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'd0,
      CAUSE_MISALIGNED = 2'd1,
      CAUSE_ILLEGAL    = 2'd2
   } trap_cause_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_cond.sv
// Combinational RV32I conditional-branch resolver: funct3, a, b -> taken, illegal.
// Unused funct3 encodings resolve to not-taken with illegal set.
module branch_cond
   import branch_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        taken,
   output logic        illegal
);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  taken = (a == b);
         F3_BNE:  taken = (a != b);
         F3_BLT:  taken = ($signed(a) <  $signed(b));
         F3_BGE:  taken = ($signed(a) >= $signed(b));
         F3_BLTU: taken = (a <  b);
         F3_BGEU: taken = (a >= b);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_pc_controller.sv
// Architectural PC owner: IDLE -> EVAL -> COMMIT/TRAP per instruction.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module branch_pc_controller
   import branch_pkg::*;
#(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic            dec_is_branch,
   input  logic [2:0]      dec_funct3,
   input  logic [XLEN-1:0] dec_rs1_val,
   input  logic [XLEN-1:0] dec_rs2_val,
   input  logic [XLEN-1:0] dec_imm,
   output logic [XLEN-1:0] pc,
   output logic            flush,
   output logic            retire,
   output logic            trap,
   output logic [1:0]      trap_cause
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     taken_count,
   output logic [31:0]     not_taken_count
`endif
);

   localparam logic [XLEN-1:0] IMM_MASK = {{(XLEN-1){1'b1}}, 1'b0};
   localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              is_branch_q, is_branch_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
   logic              taken_q, taken_d;
   logic [XLEN-1:0]   target_q, target_d, seq_q, seq_d;
   trap_cause_e       cause_q, cause_d;

   logic              cond_taken, cond_illegal;
   logic [XLEN-1:0]   eval_target;

   branch_cond u_cond (
      .funct3  (funct3_q),
      .a       (rs1_q),
      .b       (rs2_q),
      .taken   (cond_taken),
      .illegal (cond_illegal)
   );

   // Ready is forced low while reset is held, not just after the first edge.
   assign dec_ready  = (state_q == IDLE) && reset_n;
   assign pc         = pc_q;
   assign retire     = (state_q == COMMIT);
   assign flush      = (state_q == COMMIT) && taken_q;
   assign trap       = (state_q == TRAP);
   assign trap_cause = (state_q == TRAP) ? cause_q : CAUSE_NONE;

   assign eval_target = pc_q + (imm_q & IMM_MASK);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      is_branch_d = is_branch_q;
      funct3_d    = funct3_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      imm_d       = imm_q;
      taken_d     = taken_q;
      target_d    = target_q;
      seq_d       = seq_q;
      cause_d     = cause_q;
      case (state_q)
         IDLE: begin
            if (dec_valid && dec_ready) begin
               is_branch_d = dec_is_branch;
               funct3_d    = dec_funct3;
               rs1_d       = dec_rs1_val;
               rs2_d       = dec_rs2_val;
               imm_d       = dec_imm;
               state_d     = EVAL;
            end
         end
         EVAL: begin
            taken_d  = is_branch_q && cond_taken;
            target_d = eval_target;
            seq_d    = pc_q + INSN_BYTES;
            cause_d  = CAUSE_NONE;
            state_d  = COMMIT;
            if (is_branch_q && cond_illegal) begin
               cause_d = CAUSE_ILLEGAL;
               state_d = TRAP;
            end else if (is_branch_q && cond_taken && eval_target[1]) begin
               cause_d = CAUSE_MISALIGNED;
               state_d = TRAP;
            end
         end
         COMMIT: begin
            pc_d    = taken_q ? target_q : seq_q;
            state_d = IDLE;
         end
         TRAP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         is_branch_q <= 1'b0;
         funct3_q    <= 3'd0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
         taken_q     <= 1'b0;
         target_q    <= '0;
         seq_q       <= '0;
         cause_q     <= CAUSE_NONE;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         is_branch_q <= is_branch_d;
         funct3_q    <= funct3_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         imm_q       <= imm_d;
         taken_q     <= taken_d;
         target_q    <= target_d;
         seq_q       <= seq_d;
         cause_q     <= cause_d;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] taken_count_q, taken_count_d;
   logic [31:0] not_taken_count_q, not_taken_count_d;

   // Only committed branches count; trapped instructions never reach COMMIT.
   always_comb begin
      taken_count_d     = taken_count_q;
      not_taken_count_d = not_taken_count_q;
      if (state_q == COMMIT && is_branch_q) begin
         if (taken_q) begin
            if (taken_count_q != '1) taken_count_d = taken_count_q + 32'd1;
         end else begin
            if (not_taken_count_q != '1) not_taken_count_d = not_taken_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         taken_count_q     <= '0;
         not_taken_count_q <= '0;
      end else begin
         taken_count_q     <= taken_count_d;
         not_taken_count_q <= not_taken_count_d;
      end
   end

   assign taken_count     = taken_count_q;
   assign not_taken_count = not_taken_count_q;
`endif

endmodule

// File: tb/tb_branch_pc_controller.sv
// Scoreboard bench for branch_pc_controller: directed instructions push expected
// commit/trap responses; a monitor pops them whenever retire or trap pulses.
module tb_branch_pc_controller;

   typedef struct {
      logic        flush;
      logic        trap;
      logic [1:0]  cause;
      logic [31:0] pc_old;
      logic [31:0] pc_new;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        dec_valid;
   logic        dec_ready;
   logic        dec_is_branch;
   logic [2:0]  dec_funct3;
   logic [31:0] dec_rs1_val, dec_rs2_val, dec_imm;
   logic [31:0] pc;
   logic        flush, retire, trap;
   logic [1:0]  trap_cause;
`ifdef BRANCH_STATS_EN
   logic [31:0] taken_count, not_taken_count;
`endif

   int   checks = 0;
   int   passes = 0;
   exp_t exp_q[$];
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   branch_pc_controller #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_is_branch   (dec_is_branch),
      .dec_funct3      (dec_funct3),
      .dec_rs1_val     (dec_rs1_val),
      .dec_rs2_val     (dec_rs2_val),
      .dec_imm         (dec_imm),
      .pc              (pc),
      .flush           (flush),
      .retire          (retire),
      .trap            (trap),
      .trap_cause      (trap_cause)
`ifdef BRANCH_STATS_EN
      ,
      .taken_count     (taken_count),
      .not_taken_count (not_taken_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: actual=%h required=%h", name, act, req);
   endtask

   // Drive one instruction, queue its expected outcome, then scramble the inputs.
   task automatic issue(input logic br, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic exp_flush,
                        input logic exp_trap, input logic [1:0] exp_cause, input logic [31:0] pc_new);
      int n;
      n = 0;
      while (!dec_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_issue", 32'(dec_ready), 32'd1);
      dec_valid     = 1'b1;
      dec_is_branch = br;
      dec_funct3    = f3;
      dec_rs1_val   = a;
      dec_rs2_val   = b;
      dec_imm       = imm;
      exp_q.push_back('{exp_flush, exp_trap, exp_cause, exp_pc, pc_new});
      exp_pc = pc_new;
      @(posedge clk);
      #1;
      dec_valid     = 1'b0;
      dec_is_branch = ~br;
      dec_funct3    = 3'($urandom);
      dec_rs1_val   = $urandom;
      dec_rs2_val   = $urandom;
      dec_imm       = $urandom;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dec_ready && n < 10);
      check("ready_latency", 32'(n), 32'd3);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_flush"},  32'(flush),  32'd0);
      check({tag, "_retire"}, 32'(retire), 32'd0);
      check({tag, "_trap"},   32'(trap),   32'd0);
   endtask

   // Monitor: pops one expectation per retire/trap pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && (retire || trap)) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_pulse: actual retire=%0b trap=%0b required no pulse", retire, trap);
            end else begin
               e = exp_q.pop_front();
               check("retire",     32'(retire),     32'(!e.trap));
               check("trap",       32'(trap),       32'(e.trap));
               check("flush",      32'(flush),      32'(e.flush));
               check("trap_cause", 32'(trap_cause), 32'(e.cause));
               check("pc_in_pulse", pc, e.pc_old);
               @(negedge clk);
               check("pc_after", pc, e.pc_new);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset_n       = 1'b0;
      dec_valid     = 1'b0;
      dec_is_branch = 1'b0;
      dec_funct3    = 3'd0;
      dec_rs1_val   = '0;
      dec_rs2_val   = '0;
      dec_imm       = '0;
      exp_pc        = 32'h0000_0100;

      repeat (3) @(negedge clk);
      check("rst_pc",    pc, 32'h0000_0100);
      check("rst_ready", 32'(dec_ready), 32'd0);
      check("rst_cause", 32'(trap_cause), 32'd0);
      check_quiet("rst");
      reset_n = 1'b1;
      #1;
      check("rel_ready", 32'(dec_ready), 32'd1);
      check_quiet("rel");

      //    br    f3    rs1           rs2           imm           fl    tr    cause  new pc
      issue(1'b0, 3'd0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 2'd0, 32'h0000_0104);
      issue(1'b1, 3'd0, 32'd5,        32'd5,        32'h0000_00FC, 1'b1, 1'b0, 2'd0, 32'h0000_0200);
      issue(1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFF8, 1'b1, 1'b0, 2'd0, 32'h0000_01F8);
      issue(1'b1, 3'd5, 32'd0,        32'd0,        32'h0000_0008, 1'b1, 1'b0, 2'd0, 32'h0000_0200);
      issue(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFF8, 1'b0, 1'b0, 2'd0, 32'h0000_0204);
      issue(1'b1, 3'd1, 32'd1,        32'd2,        32'h0000_00FC, 1'b1, 1'b0, 2'd0, 32'h0000_0300);
      issue(1'b1, 3'd0, 32'd9,        32'd9,        32'h0000_0006, 1'b0, 1'b1, 2'd1, 32'h0000_0300);
      issue(1'b1, 3'd2, 32'd9,        32'd9,        32'h0000_0008, 1'b0, 1'b1, 2'd2, 32'h0000_0300);
      issue(1'b1, 3'd3, 32'd1,        32'd2,        32'h0000_0008, 1'b0, 1'b1, 2'd2, 32'h0000_0300);
      issue(1'b0, 3'd3, 32'd1,        32'd2,        32'h0000_0008, 1'b0, 1'b0, 2'd0, 32'h0000_0304);
      issue(1'b1, 3'd1, 32'd7,        32'd7,        32'h0000_0006, 1'b0, 1'b0, 2'd0, 32'h0000_0308);
      issue(1'b1, 3'd7, 32'd1,        32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 1'b0, 2'd0, 32'h0000_030C);
      issue(1'b1, 3'd0, 32'd0,        32'd0,        32'h0000_0005, 1'b1, 1'b0, 2'd0, 32'h0000_0310);
      issue(1'b1, 3'd1, 32'd0,        32'd1,        32'hFFFF_FCEC, 1'b1, 1'b0, 2'd0, 32'hFFFF_FFFC);
      issue(1'b0, 3'd0, 32'd0,        32'd0,        32'h0,        1'b0, 1'b0, 2'd0, 32'h0000_0000);
      issue(1'b1, 3'd4, 32'd1,        32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 1'b0, 2'd0, 32'h0000_0004);
      issue(1'b1, 3'd5, 32'h8000_0000, 32'd0,       32'h0000_0010, 1'b0, 1'b0, 2'd0, 32'h0000_0008);
      issue(1'b1, 3'd7, 32'hFFFF_FFFF, 32'd1,       32'h0000_0010, 1'b1, 1'b0, 2'd0, 32'h0000_0018);

      // Reset while a taken BNE sits in EVAL: no pulses, pc back to reset value.
      dec_valid     = 1'b1;
      dec_is_branch = 1'b1;
      dec_funct3    = 3'd1;
      dec_rs1_val   = 32'd1;
      dec_rs2_val   = 32'd2;
      dec_imm       = 32'h0000_0040;
      @(posedge clk);
      #1;
      dec_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_pc",    pc, 32'h0000_0100);
      check("abort_ready", 32'(dec_ready), 32'd0);
      check_quiet("abort");
      repeat (2) begin
         @(negedge clk);
         check_quiet("abort_hold");
      end
      reset_n = 1'b1;
      exp_pc  = 32'h0000_0100;
      #1;
      check("abort_rel_ready", 32'(dec_ready), 32'd1);
      check("abort_rel_pc",    pc, 32'h0000_0100);
`ifdef BRANCH_STATS_EN
      check("stats_clear_taken",     taken_count,     32'd0);
      check("stats_clear_not_taken", not_taken_count, 32'd0);
`endif

      // Three taken and two not-taken branches, plus a non-branch and a trap.
      issue(1'b1, 3'd0, 32'd1, 32'd1, 32'h0000_0008, 1'b1, 1'b0, 2'd0, 32'h0000_0108);
      issue(1'b1, 3'd1, 32'd1, 32'd1, 32'h0000_0008, 1'b0, 1'b0, 2'd0, 32'h0000_010C);
      issue(1'b1, 3'd6, 32'd1, 32'd2, 32'h0000_0004, 1'b1, 1'b0, 2'd0, 32'h0000_0110);
      issue(1'b1, 3'd5, 32'd0, 32'd1, 32'h0000_0004, 1'b0, 1'b0, 2'd0, 32'h0000_0114);
      issue(1'b1, 3'd7, 32'd2, 32'd1, 32'h0000_000C, 1'b1, 1'b0, 2'd0, 32'h0000_0120);
      issue(1'b0, 3'd0, 32'd0, 32'd0, 32'h0,         1'b0, 1'b0, 2'd0, 32'h0000_0124);
      issue(1'b1, 3'd2, 32'd0, 32'd0, 32'h0000_0008, 1'b0, 1'b1, 2'd2, 32'h0000_0124);

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef BRANCH_STATS_EN
      check("stats_taken",     taken_count,     32'd3);
      check("stats_not_taken", not_taken_count, 32'd2);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
